i2c_slave_regif: RTL and testbench

- I2C target (slave) responder for the pif register interface. It sits between the SDA/SCL pad buffers and the flasher register bank.
- Decodes bytes written by the host into tagged address and data writes. Serves register reads back to the host.
- Byte format is {tag[1:0], value[`I2C_DATA_BITS-1:0]}, with `I2C_DATA_BITS = 6.
- Fully synchronous to CLK. SCL is oversampled, never used as a clock.

---
 rtl/i2c_slave_regif_pkg.sv | 32 +++
 rtl/i2c_slave_regif_if.sv | 40 ++++
 rtl/i2c_pin_filter.sv | 51 +++++
 rtl/i2c_slave_regif.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_regif_pkg.sv
// Shared constants, byte-format helpers and FSM encoding for the I2C register responder.
// Byte format on the wire: {tag[1:0], value[5:0]}, MSB first.
package i2c_slave_regif_pkg;

    localparam int unsigned I2C_DATA_BITS = 6;
    localparam int unsigned I2C_TYPE_BITS = 2;
    localparam int unsigned I2C_BYTE_BITS = I2C_TYPE_BITS + I2C_DATA_BITS;

    localparam logic [I2C_TYPE_BITS-1:0] A_ADDR = 2'b00;
    localparam logic [I2C_TYPE_BITS-1:0] D_ADDR = 2'b01;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StAddr     = 4'd1,
        StAddrAck  = 4'd2,
        StWrByte   = 4'd3,
        StWrAck    = 4'd4,
        StRdLoad   = 4'd5,
        StRdByte   = 4'd6,
        StRdAck    = 4'd7,
        StWaitStop = 4'd8
    } state_t;

    function automatic logic [I2C_TYPE_BITS-1:0] byte_tag(input logic [I2C_BYTE_BITS-1:0] b);
        return b[I2C_BYTE_BITS-1 -: I2C_TYPE_BITS];
    endfunction

    function automatic logic [I2C_DATA_BITS-1:0] byte_value(input logic [I2C_BYTE_BITS-1:0] b);
        return b[I2C_DATA_BITS-1:0];
    endfunction

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Pad-side and register-bank-side signals of the I2C register responder.
// The slave modport is the responder's view; master is the pads/register bank view.
interface i2c_slave_regif_if;
    import i2c_slave_regif_pkg::*;

    logic                     SCL_IN;
    logic                     SDA_IN;
    logic                     SDA_OE;
    logic [I2C_DATA_BITS-1:0] REG_ADDR;
    logic [I2C_DATA_BITS-1:0] REG_WDATA;
    logic                     REG_WE;
    logic                     REG_RE;
    logic [I2C_DATA_BITS-1:0] REG_RDATA;
    logic                     BUSY;

    modport slave (
        input  SCL_IN,
        input  SDA_IN,
        input  REG_RDATA,
        output SDA_OE,
        output REG_ADDR,
        output REG_WDATA,
        output REG_WE,
        output REG_RE,
        output BUSY
    );

    modport master (
        output SCL_IN,
        output SDA_IN,
        output REG_RDATA,
        input  SDA_OE,
        input  REG_ADDR,
        input  REG_WDATA,
        input  REG_WE,
        input  REG_RE,
        input  BUSY
    );

endinterface

// File: rtl/i2c_pin_filter.sv
// Pad input conditioning: 2-FF synchronizer, FILTER_LEN-sample glitch filter and edge pulses.
// The filtered level idles high (released bus); edge pulses coincide with the level update.
module i2c_pin_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]      r_sync;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic [CntW-1:0] r_cnt;

    // The level flips only after FILTER_LEN consecutive synchronized samples disagree with it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CntW'(FILTER_LEN - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target that turns tagged host bytes into register-bank writes and serves reads.
// Optional burst address auto-increment is enabled by defining I2C_AUTOINC_EN.
module i2c_slave_regif
    import i2c_slave_regif_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR   = 7'h41,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic               CLK,
    input  logic               GSRn,
    i2c_slave_regif_if.slave   bus
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_pin_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_scl_filter (
        .i_clk   (CLK),
        .i_rst_n (GSRn),
        .i_pin   (bus.SCL_IN),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_pin_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sda_filter (
        .i_clk   (CLK),
        .i_rst_n (GSRn),
        .i_pin   (bus.SDA_IN),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    state_t                   r_state,     w_state_nxt;
    logic [I2C_BYTE_BITS-1:0] r_shift,     w_shift_nxt;
    logic [2:0]               r_bitcnt,    w_bitcnt_nxt;
    logic                     r_rw,        w_rw_nxt;
    logic                     r_nack,      w_nack_nxt;
    logic                     r_rd_phase,  w_rd_phase_nxt;
    logic                     r_sda_oe,    w_sda_oe_nxt;
    logic [I2C_DATA_BITS-1:0] r_reg_addr,  w_reg_addr_nxt;
    logic [I2C_DATA_BITS-1:0] r_reg_wdata, w_reg_wdata_nxt;
    logic                     r_reg_we,    w_reg_we_nxt;
    logic                     r_reg_re,    w_reg_re_nxt;
    logic                     r_busy,      w_busy_nxt;
    logic [I2C_BYTE_BITS-1:0] w_shift_in;
    logic [I2C_BYTE_BITS-1:0] w_rd_word;

    assign w_shift_in = {r_shift[I2C_BYTE_BITS-2:0], w_sda};
    assign w_rd_word  = {D_ADDR, bus.REG_RDATA};

    always_ff @(posedge CLK) begin
        if (!GSRn) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_rw        <= 1'b0;
            r_nack      <= 1'b0;
            r_rd_phase  <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_rw        <= w_rw_nxt;
            r_nack      <= w_nack_nxt;
            r_rd_phase  <= w_rd_phase_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_reg_re    <= w_reg_re_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bitcnt_nxt    = r_bitcnt;
        w_rw_nxt        = r_rw;
        w_nack_nxt      = r_nack;
        w_rd_phase_nxt  = r_rd_phase;
        w_sda_oe_nxt    = r_sda_oe;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_we_nxt    = 1'b0;
        w_reg_re_nxt    = 1'b0;
        w_busy_nxt      = r_busy;

`ifdef I2C_AUTOINC_EN
        if (r_reg_we || r_reg_re) begin
            w_reg_addr_nxt = r_reg_addr + 6'd1;
        end
`endif

        if (w_stop) begin
            w_state_nxt  = StIdle;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt    = StAddr;
            w_bitcnt_nxt   = '0;
            w_sda_oe_nxt   = 1'b0;
            w_rd_phase_nxt = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StAddr: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_shift_in;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            if (w_shift_in[7:1] == I2C_ADDR) begin
                                w_state_nxt = StAddrAck;
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = w_shift_in[0];
                            end else begin
                                w_state_nxt = StWaitStop;
                            end
                        end
                    end
                end
                // First SCL fall drives the ACK low, the second one releases it.
                StAddrAck, StWrAck: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt   = 1'b0;
                            w_bitcnt_nxt   = '0;
                            w_rd_phase_nxt = 1'b0;
                            if (r_state == StAddrAck && r_rw) begin
                                w_state_nxt = StRdLoad;
                            end else begin
                                w_state_nxt = StWrByte;
                            end
                        end
                    end
                end
                StWrByte: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_shift_in;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            w_state_nxt = StWrAck;
                            if (byte_tag(w_shift_in) == A_ADDR) begin
                                w_reg_addr_nxt = byte_value(w_shift_in);
                            end else if (byte_tag(w_shift_in) == D_ADDR) begin
                                w_reg_wdata_nxt = byte_value(w_shift_in);
                                w_reg_we_nxt    = 1'b1;
                            end
                        end
                    end
                end
                // Strobe first, capture REG_RDATA on the following CLK and drive its MSB at once.
                StRdLoad: begin
                    if (!r_rd_phase) begin
                        w_reg_re_nxt   = 1'b1;
                        w_rd_phase_nxt = 1'b1;
                    end else begin
                        w_shift_nxt    = w_rd_word;
                        w_sda_oe_nxt   = ~w_rd_word[I2C_BYTE_BITS-1];
                        w_bitcnt_nxt   = '0;
                        w_rd_phase_nxt = 1'b0;
                        w_state_nxt    = StRdByte;
                    end
                end
                StRdByte: begin
                    if (w_scl_fall) begin
                        if (r_bitcnt == 3'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_bitcnt_nxt = '0;
                            w_state_nxt  = StRdAck;
                        end else begin
                            w_shift_nxt  = {r_shift[I2C_BYTE_BITS-2:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[I2C_BYTE_BITS-2];
                            w_bitcnt_nxt = r_bitcnt + 3'd1;
                        end
                    end
                end
                // Host ACK is sampled on the rise; the state moves on the following fall so SDA
                // never changes while SCL is high.
                StRdAck: begin
                    if (w_scl_rise) begin
                        w_nack_nxt = w_sda;
                    end else if (w_scl_fall) begin
                        w_rd_phase_nxt = 1'b0;
                        w_state_nxt    = r_nack ? StWaitStop : StRdLoad;
                    end
                end
                StWaitStop: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = StIdle;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.SDA_OE    = r_sda_oe;
    assign bus.REG_ADDR  = r_reg_addr;
    assign bus.REG_WDATA = r_reg_wdata;
    assign bus.REG_WE    = r_reg_we;
    assign bus.REG_RE    = r_reg_re;
    assign bus.BUSY      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C host, table-driven write bytes, scoreboarded
// register writes and read bytes. Expectations track I2C_AUTOINC_EN when it is defined.
module tb_i2c_slave_regif;
    import i2c_slave_regif_pkg::*;

    localparam int Q = 8;  // CLK cycles per quarter SCL period
`ifdef I2C_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic CLK = 1'b0;
    logic GSRn;
    logic r_scl;
    logic r_sda;

    i2c_slave_regif_if ifc ();

    i2c_slave_regif #(
        .I2C_ADDR   (7'h41),
        .FILTER_LEN (3)
    ) dut (
        .CLK  (CLK),
        .GSRn (GSRn),
        .bus  (ifc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] rd_val(input logic [5:0] a);
        return a ^ 6'h28;
    endfunction

    assign ifc.SCL_IN    = r_scl;
    assign ifc.SDA_IN    = r_sda & ~ifc.SDA_OE;
    assign ifc.REG_RDATA = rd_val(ifc.REG_ADDR);

    typedef struct packed {
        logic [5:0] addr;
        logic [5:0] data;
    } wr_exp_t;

    typedef struct {
        logic [7:0] data;
        int         glitch;
        logic [5:0] exp_addr;
    } wr_vec_t;

    wr_exp_t    sb_wr[$];
    logic [7:0] sb_rd[$];
    logic [5:0] m_addr;
    wr_vec_t    vecs[10];

    int n_total = 0;
    int n_pass  = 0;
    int n_we = 0, n_re = 0, n_extra_we = 0, n_long = 0, n_overlap = 0;
    bit oe_seen = 1'b0;
    logic prev_we = 1'b0, prev_re = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (ifc.REG_WE) begin
            n_we++;
            if (sb_wr.size() == 0) begin
                n_extra_we++;
            end else begin
                wr_exp_t e;
                e = sb_wr.pop_front();
                check("we_addr", 32'(ifc.REG_ADDR), 32'(e.addr));
                check("we_data", 32'(ifc.REG_WDATA), 32'(e.data));
            end
        end
        if (ifc.REG_RE) n_re++;
        if ((ifc.REG_WE && prev_we) || (ifc.REG_RE && prev_re)) n_long++;
        if (ifc.REG_WE && ifc.REG_RE) n_overlap++;
        if (ifc.SDA_OE) oe_seen = 1'b1;
        prev_we = ifc.REG_WE;
        prev_re = ifc.REG_RE;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic i2c_start();
        if (!r_scl) begin
            r_sda = 1'b1; idle(Q);
            r_scl = 1'b1; idle(Q);
        end
        r_sda = 1'b0; idle(2 * Q);
        r_scl = 1'b0; idle(Q);
    endtask

    task automatic i2c_stop();
        r_sda = 1'b0; idle(Q);
        r_scl = 1'b1; idle(2 * Q);
        r_sda = 1'b1; idle(2 * Q);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        r_sda = b;
        if (glitch) begin
            idle(2);
            r_scl = 1'b1; idle(1);
            r_scl = 1'b0; idle(Q - 3);
        end else begin
            idle(Q);
        end
        r_scl = 1'b1; idle(2 * Q);
        r_scl = 1'b0; idle(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], glitch == i);
        r_sda = 1'b1; idle(Q);
        r_scl = 1'b1; idle(Q);
        ack = ifc.SDA_IN; idle(Q);
        r_scl = 1'b0; idle(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe9);
        for (int i = 7; i >= 0; i--) begin
            r_sda = 1'b1; idle(Q);
            r_scl = 1'b1; idle(Q);
            d[i] = ifc.SDA_IN; idle(Q);
            r_scl = 1'b0; idle(Q);
        end
        r_sda = nack; idle(Q);
        r_scl = 1'b1; idle(Q);
        oe9 = ifc.SDA_OE; idle(Q);
        r_scl = 1'b0; idle(Q);
    endtask

    // Reference model of the register pointer and expected bank traffic.
    task automatic model_byte(input logic [7:0] b);
        if (b[7:6] == 2'b00) begin
            m_addr = b[5:0];
        end else if (b[7:6] == 2'b01) begin
            sb_wr.push_back('{addr: m_addr, data: b[5:0]});
            if (AUTOINC) m_addr = m_addr + 6'd1;
        end
    endtask

    task automatic model_read();
        sb_rd.push_back({2'b01, rd_val(m_addr)});
        if (AUTOINC) m_addr = m_addr + 6'd1;
    endtask

    task automatic wr(input logic [7:0] b, input string name);
        logic ack;
        model_byte(b);
        write_byte(b, 8, ack);
        check(name, 32'(ack), 32'd0);
    endtask

    initial begin
        logic       ack, oe9;
        logic [7:0] d;
        int         we0, re0;

        vecs[0] = '{data: 8'h02, glitch: 8, exp_addr: 6'd2};
        vecs[1] = '{data: 8'h41, glitch: 8, exp_addr: AUTOINC ? 6'd3 : 6'd2};
        vecs[2] = '{data: 8'hBF, glitch: 8, exp_addr: AUTOINC ? 6'd3 : 6'd2};
        vecs[3] = '{data: 8'hC0, glitch: 8, exp_addr: AUTOINC ? 6'd3 : 6'd2};
        vecs[4] = '{data: 8'h2D, glitch: 8, exp_addr: 6'd45};
        vecs[5] = '{data: 8'h55, glitch: 3, exp_addr: AUTOINC ? 6'd46 : 6'd45};
        vecs[6] = '{data: 8'h7F, glitch: 8, exp_addr: AUTOINC ? 6'd47 : 6'd45};
        vecs[7] = '{data: 8'h3F, glitch: 8, exp_addr: 6'd63};
        vecs[8] = '{data: 8'h45, glitch: 6, exp_addr: AUTOINC ? 6'd0 : 6'd63};
        vecs[9] = '{data: 8'h46, glitch: 8, exp_addr: AUTOINC ? 6'd1 : 6'd63};

        GSRn = 1'b0; r_scl = 1'b1; r_sda = 1'b1; m_addr = '0;
        idle(5);
        check("rst_sda_oe", 32'(ifc.SDA_OE), 32'd0);
        check("rst_reg_addr", 32'(ifc.REG_ADDR), 32'd0);
        check("rst_reg_wdata", 32'(ifc.REG_WDATA), 32'd0);
        check("rst_reg_we", 32'(ifc.REG_WE), 32'd0);
        check("rst_reg_re", 32'(ifc.REG_RE), 32'd0);
        check("rst_busy", 32'(ifc.BUSY), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(StIdle));
        GSRn = 1'b1;
        idle(10);

        // Table-driven write transaction, including ignored tags, glitches and address wrap.
        i2c_start();
        write_byte(8'h82, 8, ack);
        check("addr_ack", 32'(ack), 32'd0);
        check("busy_after_match", 32'(ifc.BUSY), 32'd1);
        for (int i = 0; i < 10; i++) begin
            model_byte(vecs[i].data);
            write_byte(vecs[i].data, vecs[i].glitch, ack);
            check($sformatf("wr_ack[%0d]", i), 32'(ack), 32'd0);
            check($sformatf("reg_addr[%0d]", i), 32'(ifc.REG_ADDR), 32'(vecs[i].exp_addr));
        end
        i2c_stop();
        check("busy_after_stop", 32'(ifc.BUSY), 32'd0);
        check("wr_sb_drained", 32'(sb_wr.size()), 32'd0);
        check("we_count", 32'(n_we), 32'd5);

        // Foreign address: never driven, no bank traffic, parked until STOP.
        we0 = n_we; re0 = n_re; oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h84, 8, ack);
        check("nack_addr", 32'(ack), 32'd1);
        check("nack_busy", 32'(ifc.BUSY), 32'd0);
        write_byte(8'h41, 8, ack);
        check("nack_data", 32'(ack), 32'd1);
        check("nack_state", 32'(dut.r_state), 32'(StWaitStop));
        i2c_stop();
        check("nack_state_stop", 32'(dut.r_state), 32'(StIdle));
        check("nack_oe_never", 32'(oe_seen), 32'd0);
        check("nack_no_we", 32'(n_we - we0), 32'd0);
        check("nack_no_re", 32'(n_re - re0), 32'd0);

        // Pointer write, repeated START, single read with host NACK.
        re0 = n_re;
        i2c_start();
        wr(8'h82, "rd_wr_addr_ack");
        wr(8'h02, "rd_ptr_ack");
        i2c_start();
        write_byte(8'h83, 8, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        model_read();
        read_byte(1'b1, d, oe9);
        check("rd_byte_0x6a", 32'(d), 32'(sb_rd.pop_front()));
        check("rd_oe9_released", 32'(oe9), 32'd0);
        check("rd_state_nack", 32'(dut.r_state), 32'(StWaitStop));
        i2c_stop();
        check("rd_re_count", 32'(n_re - re0), 32'd1);
        check("rd_busy_stop", 32'(ifc.BUSY), 32'd0);

        // Burst read: ACK, ACK, NACK.
        re0 = n_re;
        i2c_start();
        wr(8'h82, "brd_wr_addr_ack");
        wr(8'h0A, "brd_ptr_ack");
        i2c_start();
        write_byte(8'h83, 8, ack);
        check("brd_addr_ack", 32'(ack), 32'd0);
        for (int k = 0; k < 3; k++) begin
            model_read();
            read_byte(k == 2, d, oe9);
            check($sformatf("brd_byte[%0d]", k), 32'(d), 32'(sb_rd.pop_front()));
            check($sformatf("brd_oe9[%0d]", k), 32'(oe9), 32'd0);
        end
        i2c_stop();
        check("brd_re_count", 32'(n_re - re0), 32'd3);
        check("brd_reg_addr", 32'(ifc.REG_ADDR), 32'(m_addr));

        // Reset after the 4th bit of a data byte, then a clean transaction.
        we0 = n_we;
        i2c_start();
        wr(8'h82, "grst_addr_ack");
        for (int i = 7; i >= 4; i--) send_bit(d[0] ^ 1'b1 ? 1'b0 : 1'b0, 1'b0);
        GSRn = 1'b0;
        idle(1);
        check("grst_sda_oe", 32'(ifc.SDA_OE), 32'd0);
        check("grst_busy", 32'(ifc.BUSY), 32'd0);
        idle(2);
        GSRn = 1'b1;
        m_addr = '0;
        idle(10);
        i2c_stop();
        check("grst_no_we", 32'(n_we - we0), 32'd0);
        i2c_start();
        wr(8'h82, "post_rst_addr_ack");
        wr(8'h05, "post_rst_ptr_ack");
        wr(8'h49, "post_rst_data_ack");
        i2c_stop();
        check("post_rst_we", 32'(n_we - we0), 32'd1);
        check("post_rst_reg_addr", 32'(ifc.REG_ADDR), AUTOINC ? 32'd6 : 32'd5);

        check("wr_sb_final", 32'(sb_wr.size()), 32'd0);
        check("extra_we", 32'(n_extra_we), 32'd0);
        check("strobe_width", 32'(n_long), 32'd0);
        check("we_re_overlap", 32'(n_overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
